// File: rtl/mdu_sequencer.sv
// Execute-stage multiply/divide sequencer: HI/LO ownership, multi-cycle busy timing, D-stage stall.
// Optional MDU_DIV0_FAST_EN: divide-by-zero retires immediately without touching HI/LO.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic [3:0]  E_MDUop,
  input  logic        E_MDU_start,
  input  logic        E_MDUout_sel,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_MDU_use,
  output logic [31:0] E_MDU_out,
  output logic        E_MDU_busy,
  output logic        D_MDU_stall
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi, lo, p_hi, p_lo;
  logic        md_op, div_zero, skip;
  logic [63:0] prod_s, prod_u, res;
  logic [31:0] abs_rs, abs_rt, dvsr_u, dvsr_s, uq, ur, sq, sr;

  assign md_op    = (E_MDUop >= 4'd1) && (E_MDUop <= 4'd4);
  assign div_zero = (E_rt_data == 32'd0);

`ifdef MDU_DIV0_FAST_EN
  assign skip = ((E_MDUop == 4'd3) || (E_MDUop == 4'd4)) && div_zero;
`else
  assign skip = 1'b0;
`endif

  // Sign-extended operands keep the low 64 bits of the unsigned product equal to the signed product.
  assign prod_s = {{32{E_rs_data[31]}}, E_rs_data} * {{32{E_rt_data[31]}}, E_rt_data};
  assign prod_u = {32'd0, E_rs_data} * {32'd0, E_rt_data};

  // Divisor forced non-zero so the dividers never see 0; the zero case is overridden below.
  assign abs_rs = E_rs_data[31] ? -E_rs_data : E_rs_data;
  assign abs_rt = E_rt_data[31] ? -E_rt_data : E_rt_data;
  assign dvsr_u = div_zero ? 32'd1 : E_rt_data;
  assign dvsr_s = div_zero ? 32'd1 : abs_rt;
  assign uq     = E_rs_data / dvsr_u;
  assign ur     = E_rs_data % dvsr_u;
  assign sq     = (E_rs_data[31] ^ E_rt_data[31]) ? -(abs_rs / dvsr_s) : (abs_rs / dvsr_s);
  assign sr     = E_rs_data[31] ? -(abs_rs % dvsr_s) : (abs_rs % dvsr_s);

  always_comb begin
    res = 64'd0;
    case (E_MDUop)
      4'd1:    res = prod_s;
      4'd2:    res = prod_u;
      4'd3:    res = div_zero ? {E_rs_data, 32'hFFFF_FFFF} : {sr, sq};
      4'd4:    res = div_zero ? {E_rs_data, 32'hFFFF_FFFF} : {ur, uq};
      default: res = 64'd0;
    endcase
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      p_hi       <= 32'd0;
      p_lo       <= 32'd0;
      E_MDU_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (E_MDU_start) begin
          if (md_op && !skip) begin
            {p_hi, p_lo} <= res;
            cnt          <= (E_MDUop <= 4'd2) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            E_MDU_busy   <= 1'b1;
            state        <= BUSY;
          end else if (E_MDUop == 4'd5) begin
            hi <= E_rs_data;
          end else if (E_MDUop == 4'd6) begin
            lo <= E_rs_data;
          end
        end
        BUSY: begin
          // Starts seen here are dropped; the hazard unit is expected to hold them off.
          if (cnt == 4'd1) begin
            hi         <= p_hi;
            lo         <= p_lo;
            cnt        <= 4'd0;
            E_MDU_busy <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign E_MDU_out   = E_MDUout_sel ? lo : hi;
  assign D_MDU_stall = D_MDU_use & (E_MDU_busy | (E_MDU_start & md_op));
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed HI/LO results, busy length, stall window, reset.
module tb_mdu_sequencer;
  logic        gclk = 1'b0;
  logic        grst_n;
  logic [3:0]  E_MDUop;
  logic        E_MDU_start;
  logic        E_MDUout_sel;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        D_MDU_use;
  logic [31:0] E_MDU_out;
  logic        E_MDU_busy;
  logic        D_MDU_stall;

  int n_cmp = 0;
  int n_err = 0;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .gclk(gclk), .grst_n(grst_n), .E_MDUop(E_MDUop), .E_MDU_start(E_MDU_start),
    .E_MDUout_sel(E_MDUout_sel), .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
    .D_MDU_use(D_MDU_use), .E_MDU_out(E_MDU_out), .E_MDU_busy(E_MDU_busy),
    .D_MDU_stall(D_MDU_stall)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    E_MDUout_sel = 1'b0; #1;
    chk({tag, "_hi"}, E_MDU_out, ehi);
    E_MDUout_sel = 1'b1; #1;
    chk({tag, "_lo"}, E_MDU_out, elo);
  endtask

  // Issue one op, count busy cycles (bounded), then read HI/LO.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    E_MDUop = op; E_rs_data = a; E_rt_data = b; E_MDU_start = 1'b1;
    step();
    E_MDU_start = 1'b0;
    n = 0;
    while (E_MDU_busy && n < 40) begin
      n++;
      step();
    end
    chk({tag, "_cyc"}, 32'(n), 32'(exp_n));
    rd(tag, ehi, elo);
  endtask

  initial begin
    grst_n = 1'b0; E_MDUop = 4'd0; E_MDU_start = 1'b0; E_MDUout_sel = 1'b0;
    E_rs_data = 32'd0; E_rt_data = 32'd0; D_MDU_use = 1'b0;
    #2;
    chk("rst_busy", 32'(E_MDU_busy), 32'd0);
    rd("rst", 32'd0, 32'd0);
    chk("rst_stall_idle", 32'(D_MDU_stall), 32'd0);
    D_MDU_use = 1'b1; E_MDU_start = 1'b1; E_MDUop = 4'd1; #1;
    chk("rst_stall_start", 32'(D_MDU_stall), 32'd1);
    D_MDU_use = 1'b0; E_MDU_start = 1'b0; E_MDUop = 4'd0;
    @(negedge gclk); grst_n = 1'b1;
    step();

    run_md("mult",  4'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("divu",  4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_md("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // mthi then mtlo: single-edge writes, never busy
    E_MDUop = 4'd5; E_rs_data = 32'h1234_5678; E_MDU_start = 1'b1; D_MDU_use = 1'b1; #1;
    chk("mthi_stall", 32'(D_MDU_stall), 32'd0);
    step();
    E_MDU_start = 1'b0; D_MDU_use = 1'b0;
    chk("mthi_busy", 32'(E_MDU_busy), 32'd0);
    rd("mthi", 32'h1234_5678, 32'hFFFF_FFFD);
    E_MDUop = 4'd6; E_rs_data = 32'hAABB_CCDD; E_MDU_start = 1'b1;
    step();
    E_MDU_start = 1'b0;
    chk("mtlo_busy", 32'(E_MDU_busy), 32'd0);
    rd("mtlo", 32'h1234_5678, 32'hAABB_CCDD);

    // multu with D_MDU_use held: stall in start cycle and all 5 busy cycles; mid-busy start dropped
    D_MDU_use = 1'b1; E_MDUop = 4'd2; E_rs_data = 32'hFFFF_FFFF; E_rt_data = 32'd2;
    E_MDU_start = 1'b1; #1;
    chk("multu_stall_start", 32'(D_MDU_stall), 32'd1);
    step();
    E_MDU_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("multu_busy%0d", i), 32'(E_MDU_busy), 32'd1);
      chk($sformatf("multu_stall%0d", i), 32'(D_MDU_stall), 32'd1);
      if (i == 1) begin
        E_MDUop = 4'd1; E_rs_data = 32'd3; E_rt_data = 32'd3; E_MDU_start = 1'b1;
      end
      step();
      E_MDU_start = 1'b0;
    end
    chk("multu_busy_end", 32'(E_MDU_busy), 32'd0);
    chk("multu_stall_end", 32'(D_MDU_stall), 32'd0);
    rd("multu", 32'd1, 32'hFFFF_FFFE);
    step();
    chk("multu_no_restart", 32'(E_MDU_busy), 32'd0);
    D_MDU_use = 1'b0;

    // Undefined opcodes are no-ops
    run_md("op7", 4'd7, 32'hDEAD_BEEF, 32'd1, 0, 32'd1, 32'hFFFF_FFFE);
    run_md("op0", 4'd0, 32'hDEAD_BEEF, 32'd1, 0, 32'd1, 32'hFFFF_FFFE);

`ifdef MDU_DIV0_FAST_EN
    run_md("div0", 4'd3, 32'd5, 32'd0, 0, 32'd1, 32'hFFFF_FFFE);
`else
    run_md("div0", 4'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
`endif

    // Reset in the 4th busy cycle of a divide: in-flight result discarded
    E_MDUop = 4'd4; E_rs_data = 32'd100; E_rt_data = 32'd7; E_MDU_start = 1'b1;
    step();
    E_MDU_start = 1'b0;
    step(); step(); step();
    chk("mid_busy_pre", 32'(E_MDU_busy), 32'd1);
    #2 grst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(E_MDU_busy), 32'd0);
    rd("mid_rst", 32'd0, 32'd0);
    @(negedge gclk); grst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("post_rst_busy%0d", i), 32'(E_MDU_busy), 32'd0);
    end
    rd("post_rst", 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
